// File: rtl/pcie_dllp_tx_scheduler.sv
// pcie_dllp_tx_scheduler: arbitrates Ack, Nak and UpdateFC DLLPs onto one registered transmit slot
module pcie_dllp_tx_scheduler #(
   parameter int ACK_TIMER_LIMIT = 64,
   parameter int FC_TIMER_LIMIT  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ack_req_i,
   input  logic [11:0] ack_seq_i,
   input  logic        nak_req_i,
   input  logic [11:0] nak_seq_i,
   input  logic [2:0]  fc_upd_req_i,
   input  logic [23:0] fc_hdr_credit_i,
   input  logic [35:0] fc_data_credit_i,
   output logic        dllp_valid_o,
   output logic [2:0]  dllp_type_o,
   output logic [11:0] dllp_seq_o,
   output logic [7:0]  dllp_hdr_fc_o,
   output logic [11:0] dllp_data_fc_o,
   input  logic        dllp_ready_i
);
   localparam int AW = $clog2(ACK_TIMER_LIMIT + 1);
   localparam int FW = $clog2(FC_TIMER_LIMIT);
   localparam logic [AW-1:0] ACK_LIM = AW'(ACK_TIMER_LIMIT);
   localparam logic [FW-1:0] FC_LAST = FW'(FC_TIMER_LIMIT - 1);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t          state, state_nx;
   logic            ack_pend, nak_pend, nak_sched;
   logic [11:0]     ack_seq, nak_seq;
   logic [2:0]      fc_pend, fc_clr;
   logic [AW-1:0]   ack_timer;
   logic [FW-1:0]   fc_timer;
   logic [1:0]      rr_ptr, p1, p2, fc_idx;
   logic [7:0]      fc_hdr;
   logic [11:0]     fc_data;
   logic            nak_acc, ack_acc, fc_wrap, ack_el, fc_el, take, load;
   logic            win_nak, win_ack, win_fc;
   assign dllp_valid_o = state == FULL;
   // Slot state register; reset empties the slot and drops valid immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nx;
   end
   // Request acceptance, priority arbitration (Nak > timed-out Ack > round-robin FC) and next slot state
   always_comb begin
      nak_acc  = nak_req_i && !nak_sched;
      ack_acc  = ack_req_i && !nak_acc;
      fc_wrap  = fc_timer == FC_LAST;
      ack_el   = ack_pend && ack_timer == ACK_LIM;
      fc_el    = |fc_pend;
      p1       = rr_ptr == 2'd2 ? 2'd0 : rr_ptr + 2'd1;
      p2       = rr_ptr == 2'd0 ? 2'd2 : rr_ptr - 2'd1;
      fc_idx   = fc_pend[rr_ptr] ? rr_ptr : fc_pend[p1] ? p1 : p2;
      fc_hdr   = fc_idx == 2'd0 ? fc_hdr_credit_i[7:0] : fc_idx == 2'd1 ? fc_hdr_credit_i[15:8] : fc_hdr_credit_i[23:16];
      fc_data  = fc_idx == 2'd0 ? fc_data_credit_i[11:0] : fc_idx == 2'd1 ? fc_data_credit_i[23:12] : fc_data_credit_i[35:24];
      take     = state == EMPTY || dllp_ready_i;
      load     = take && (nak_pend || ack_el || fc_el);
      win_nak  = load && nak_pend;
      win_ack  = load && !nak_pend && ack_el;
      win_fc   = load && !nak_pend && !ack_el;
      fc_clr   = win_fc ? 3'b001 << fc_idx : 3'b000;
      state_nx = take ? (load ? FULL : EMPTY) : state;
   end
   // Pending requests, coalescing Ack timer, periodic FC refresh timer and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_pend  <= 1'b0;
         nak_pend  <= 1'b0;
         nak_sched <= 1'b0;
         ack_seq   <= '0;
         nak_seq   <= '0;
         fc_pend   <= '0;
         ack_timer <= '0;
         fc_timer  <= '0;
         rr_ptr    <= '0;
      end else begin
         nak_pend  <= nak_acc || (nak_pend && !win_nak);
         nak_sched <= nak_acc || (nak_sched && !ack_req_i);
         if (nak_acc) nak_seq <= nak_seq_i;
         ack_pend  <= !nak_acc && (ack_acc || (ack_pend && !win_ack));
         if (ack_acc) ack_seq <= ack_seq_i;
         ack_timer <= (ack_acc && (!ack_pend || win_ack)) ? '0 :
                      (ack_pend && ack_timer != ACK_LIM) ? ack_timer + 1'b1 : ack_timer;
         fc_pend   <= (fc_pend & ~fc_clr) | fc_upd_req_i | {3{fc_wrap}};
         fc_timer  <= fc_wrap ? '0 : fc_timer + 1'b1;
         if (win_fc) rr_ptr <= fc_idx == 2'd2 ? 2'd0 : fc_idx + 2'd1;
      end
   end
   // Output slot contents, captured on the load edge and held until accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dllp_type_o    <= '0;
         dllp_seq_o     <= '0;
         dllp_hdr_fc_o  <= '0;
         dllp_data_fc_o <= '0;
      end else if (load) begin
         dllp_type_o    <= win_nak ? 3'd1 : win_ack ? 3'd0 : {1'b0, fc_idx} + 3'd2;
         dllp_seq_o     <= win_nak ? nak_seq : win_ack ? ack_seq : 12'd0;
         dllp_hdr_fc_o  <= win_fc ? fc_hdr : 8'd0;
         dllp_data_fc_o <= win_fc ? fc_data : 12'd0;
      end
   end
endmodule

// File: tb/tb_pcie_dllp_tx_scheduler.sv
// tb_pcie_dllp_tx_scheduler: directed checks of DLLP arbitration, coalescing, suppression and FC refresh
module tb_pcie_dllp_tx_scheduler;
   logic        clk = 1'b0;
   logic        rst;
   logic        ack_req_i, nak_req_i, dllp_ready_i;
   logic [11:0] ack_seq_i, nak_seq_i;
   logic [2:0]  fc_upd_req_i;
   logic [23:0] fc_hdr_credit_i;
   logic [35:0] fc_data_credit_i;
   logic        dllp_valid_o;
   logic [2:0]  dllp_type_o;
   logic [11:0] dllp_seq_o;
   logic [7:0]  dllp_hdr_fc_o;
   logic [11:0] dllp_data_fc_o;
   int          n_checks = 0;
   int          n_fail = 0;

   pcie_dllp_tx_scheduler dut (
      .clk(clk), .rst(rst),
      .ack_req_i(ack_req_i), .ack_seq_i(ack_seq_i),
      .nak_req_i(nak_req_i), .nak_seq_i(nak_seq_i),
      .fc_upd_req_i(fc_upd_req_i),
      .fc_hdr_credit_i(fc_hdr_credit_i), .fc_data_credit_i(fc_data_credit_i),
      .dllp_valid_o(dllp_valid_o), .dllp_type_o(dllp_type_o), .dllp_seq_o(dllp_seq_o),
      .dllp_hdr_fc_o(dllp_hdr_fc_o), .dllp_data_fc_o(dllp_data_fc_o),
      .dllp_ready_i(dllp_ready_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n, input string tag);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         step(1);
         if (dllp_valid_o !== 1'b0) seen++;
      end
      check(tag, seen, 0);
   endtask

   task automatic expect_dllp(input string tag, input logic [2:0] t, input logic [11:0] s,
                              input logic [7:0] h, input logic [11:0] d);
      check({tag, "_valid"}, dllp_valid_o, 1);
      check({tag, "_type"}, dllp_type_o, t);
      check({tag, "_seq"}, dllp_seq_o, s);
      check({tag, "_hdr"}, dllp_hdr_fc_o, h);
      check({tag, "_data"}, dllp_data_fc_o, d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      int bad;
      rst = 1'b1;
      ack_req_i = 0; nak_req_i = 0; ack_seq_i = 0; nak_seq_i = 0; fc_upd_req_i = 0;
      dllp_ready_i = 1'b1;
      fc_hdr_credit_i = 24'h332211;
      fc_data_credit_i = 36'h333222111;
      step(2);
      check("rst_valid", dllp_valid_o, 0);
      check("rst_type", dllp_type_o, 0);
      check("rst_seq", dllp_seq_o, 0);
      check("rst_hdr", dllp_hdr_fc_o, 0);
      check("rst_data", dllp_data_fc_o, 0);
      rst = 1'b0;
      // Park an NP UpdateFC in the slot, then reset asynchronously while it is held
      dllp_ready_i = 1'b0;
      fc_upd_req_i = 3'b010;
      step(1);
      fc_upd_req_i = 3'b000;
      step(1);
      expect_dllp("np_before_rst", 3'd3, 12'd0, 8'h22, 12'h222);
      #2 rst = 1'b1;
      #1 check("async_rst_valid", dllp_valid_o, 0);
      step(1);
      rst = 1'b0;
      dllp_ready_i = 1'b1;
      step(1);
      check("post_rst_valid", dllp_valid_o, 0);
      // Periodic refresh: quiet until the timer wraps, then P, NP, Cpl back to back
      idle(1023, "fc_quiet");
      step(1);
      expect_dllp("refresh_p", 3'd2, 12'd0, 8'h11, 12'h111);
      step(1);
      expect_dllp("refresh_np", 3'd3, 12'd0, 8'h22, 12'h222);
      step(1);
      expect_dllp("refresh_cpl", 3'd4, 12'd0, 8'h33, 12'h333);
      step(1);
      check("refresh_done", dllp_valid_o, 0);

      // Ack coalescing
      do_reset();
      ack_req_i = 1'b1; ack_seq_i = 12'd5;
      step(1);
      ack_seq_i = 12'd6;
      step(1);
      ack_seq_i = 12'd7;
      step(1);
      ack_req_i = 1'b0;
      idle(62, "ack_coalesce_wait");
      step(1);
      expect_dllp("ack_coalesced", 3'd0, 12'd7, 8'd0, 12'd0);
      step(1);
      check("ack_single", dllp_valid_o, 0);

      // Nak suppression
      do_reset();
      nak_req_i = 1'b1; nak_seq_i = 12'd10;
      step(1);
      nak_req_i = 1'b0;
      step(1);
      expect_dllp("nak10", 3'd1, 12'd10, 8'd0, 12'd0);
      nak_req_i = 1'b1;
      step(1);
      nak_req_i = 1'b0;
      idle(3, "nak_suppressed");
      ack_req_i = 1'b1; ack_seq_i = 12'd11;
      step(1);
      ack_req_i = 1'b0;
      nak_req_i = 1'b1; nak_seq_i = 12'd11;
      step(1);
      nak_req_i = 1'b0;
      step(1);
      expect_dllp("nak11", 3'd1, 12'd11, 8'd0, 12'd0);
      idle(70, "nak11_ack_discarded");

      // Nak overrides a pending Ack
      do_reset();
      ack_req_i = 1'b1; ack_seq_i = 12'd3;
      step(1);
      ack_req_i = 1'b0;
      step(29);
      nak_req_i = 1'b1; nak_seq_i = 12'd2;
      step(1);
      nak_req_i = 1'b0;
      step(1);
      expect_dllp("nak_over_ack", 3'd1, 12'd2, 8'd0, 12'd0);
      idle(40, "no_ack_after_nak");

      // Round-robin FC with backpressure; credits sampled at load
      do_reset();
      dllp_ready_i = 1'b0;
      fc_upd_req_i = 3'b111;
      step(1);
      fc_upd_req_i = 3'b000;
      step(1);
      expect_dllp("rr_p", 3'd2, 12'd0, 8'h11, 12'h111);
      fc_hdr_credit_i = 24'h665544;
      fc_data_credit_i = 36'h666555444;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (dllp_valid_o !== 1'b1 || dllp_type_o !== 3'd2 || dllp_hdr_fc_o !== 8'h11 || dllp_data_fc_o !== 12'h111) bad++;
      end
      check("rr_p_held", bad, 0);
      dllp_ready_i = 1'b1;
      step(1);
      expect_dllp("rr_np", 3'd3, 12'd0, 8'h55, 12'h555);
      step(1);
      expect_dllp("rr_cpl", 3'd4, 12'd0, 8'h66, 12'h666);
      step(1);
      check("rr_done", dllp_valid_o, 0);

      // Ack timer saturates while the slot is blocked
      do_reset();
      dllp_ready_i = 1'b0;
      fc_upd_req_i = 3'b001;
      ack_req_i = 1'b1; ack_seq_i = 12'd30;
      step(1);
      fc_upd_req_i = 3'b000;
      ack_req_i = 1'b0;
      step(100);
      check("blocked_type", dllp_type_o, 2);
      dllp_ready_i = 1'b1;
      step(1);
      expect_dllp("blocked_ack", 3'd0, 12'd30, 8'd0, 12'd0);
      step(1);
      check("blocked_done", dllp_valid_o, 0);

      // Ack request on the same edge the pending Ack loads
      do_reset();
      ack_req_i = 1'b1; ack_seq_i = 12'd19;
      step(1);
      ack_req_i = 1'b0;
      idle(64, "ack19_wait");
      ack_req_i = 1'b1; ack_seq_i = 12'd20;
      step(1);
      ack_req_i = 1'b0;
      expect_dllp("ack19", 3'd0, 12'd19, 8'd0, 12'd0);
      idle(64, "ack20_wait");
      step(1);
      expect_dllp("ack20", 3'd0, 12'd20, 8'd0, 12'd0);
      step(1);
      check("ack20_done", dllp_valid_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
